// File: rtl/mips_pkg.sv
// mips_pkg: ALUop encodings and multiply/divide unit types shared across the MIPS datapath.
package mips_pkg;

    localparam logic [3:0] ALUOP_MULT = 4'b0110;
    localparam logic [3:0] ALUOP_MFHI = 4'b0111;
    localparam logic [3:0] ALUOP_MFLO = 4'b1000;
    localparam logic [3:0] ALUOP_DIV  = 4'b1001;

    localparam int MDU_STEPS = 32;

    typedef enum logic [1:0] {IDLE, RUN, FIX} mdu_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle signed multiply/divide owning HI/LO, stalling the datapath until commit.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MDU_STEPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH + 1);

    mdu_state_t state, state_n;
    logic [CW-1:0] count;
    logic [2*WIDTH-1:0] acc, mul_next, div_next, prod;
    logic [WIDTH-1:0] mag, rem, abs_a, abs_b;
    logic [WIDTH:0] add_sum, shifted, diff;
    logic is_div, prod_neg, quo_neg, rem_neg, accept;

    assign accept = (state == IDLE) && start && !done;
    assign busy   = state != IDLE;
    assign stall  = busy | (start & (state == IDLE) & ~done) | (rd_req & busy);

    always_comb begin
        abs_a    = a[WIDTH-1] ? -a : a;
        abs_b    = b[WIDTH-1] ? -b : b;
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag} : '0);
        mul_next = {add_sum, acc[WIDTH-1:1]};
        shifted  = {rem, acc[WIDTH-1]};
        diff     = shifted - {1'b0, mag};
        div_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~diff[WIDTH]};
        prod     = prod_neg ? -acc : acc;
    end

    always_comb begin
        state_n = accept ? RUN
                : (state == RUN && count == CW'(1)) ? FIX
                : (state == FIX) ? IDLE
                : state;
    end

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    // Divide by zero keeps LO all ones regardless of dividend sign, so the quotient sign is suppressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            acc      <= '0;
            rem      <= '0;
            mag      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            is_div   <= 1'b0;
            prod_neg <= 1'b0;
            quo_neg  <= 1'b0;
            rem_neg  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                mag      <= op_div ? abs_b : abs_a;
                acc      <= {{WIDTH{1'b0}}, op_div ? abs_a : abs_b};
                rem      <= '0;
                count    <= CW'(WIDTH);
                is_div   <= op_div;
                prod_neg <= a[WIDTH-1] ^ b[WIDTH-1];
                quo_neg  <= (a[WIDTH-1] ^ b[WIDTH-1]) & (|b);
                rem_neg  <= a[WIDTH-1];
            end else if (state == RUN) begin
                count <= count - CW'(1);
                acc   <= is_div ? div_next : mul_next;
                rem   <= !is_div ? rem : diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            end else if (state == FIX) begin
                hi   <= is_div ? (rem_neg ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
                lo   <= is_div ? (quo_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]) : prod[WIDTH-1:0];
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for the multiply/divide unit.
module tb_mult_div_unit;

    logic clk = 1'b0;
    logic rst, start, op_div, rd_req;
    logic [31:0] a, b, hi, lo;
    logic busy, done, stall;
    int checks = 0;
    int passed = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op_div(op_div), .a(a), .b(b),
        .rd_req(rd_req), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic d);
        longint p;
        logic [31:0] q, r;
        if (!d) begin
            p = longint'($signed(x)) * longint'($signed(y));
            return p;
        end
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
    endfunction

    // Issues one operation and returns inside the done cycle (or after the cycle budget).
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic d, input int rd_at,
                          output int sc, output int bc, output int dc, output int rd_bad);
        a = x;
        b = y;
        op_div = d;
        start = 1'b1;
        exp_q.push_back(model(x, y, d));
        sc = 0;
        bc = 0;
        dc = 0;
        rd_bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (i == rd_at) rd_req = 1'b1;
            if (i == 3) begin
                a = $urandom;
                b = $urandom;
            end
            #1;
            if (rd_req && !done && !stall) rd_bad++;
            if (stall) sc++;
            if (busy) bc++;
            if (done) begin
                dc++;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic end_op();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (hi !== 32'h0) $display("FAIL reset_hi got %h want 0", hi); else passed++;
        checks++; if (lo !== 32'h0) $display("FAIL reset_lo got %h want 0", lo); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        checks++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else passed++;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mult();
        int sc, bc, dc, rb;
        logic [63:0] e;
        run_op(32'd7, 32'hFFFFFFFD, 1'b0, -1, sc, bc, dc, rb);
        e = exp_q.pop_front();
        checks++; if (hi !== e[63:32]) $display("FAIL mult_hi got %h want %h", hi, e[63:32]); else passed++;
        checks++; if (lo !== e[31:0]) $display("FAIL mult_lo got %h want %h", lo, e[31:0]); else passed++;
        checks++; if (dc !== 1) $display("FAIL mult_done got %0d want 1", dc); else passed++;
        checks++; if (sc !== 34) $display("FAIL mult_stall_cycles got %0d want 34", sc); else passed++;
        checks++; if (bc !== 33) $display("FAIL mult_busy_cycles got %0d want 33", bc); else passed++;
        checks++; if (stall !== 1'b0) $display("FAIL mult_stall_in_done got %b want 0", stall); else passed++;
        end_op();
        checks++; if (done !== 1'b0) $display("FAIL mult_done_width got %b want 0", done); else passed++;
    endtask

    task automatic test_ops();
        logic [31:0] xs[8] = '{32'd100, 32'hFFFFFFF9, 32'd5, 32'h80000000, $urandom, $urandom, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] ys[8] = '{32'd7, 32'd2, 32'd0, 32'hFFFFFFFF, $urandom, $urandom | 32'h1, 32'h80000000, 32'hFFFFFFFF};
        logic ds[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        int sc, bc, dc, rb;
        logic [63:0] e;
        for (int i = 0; i < 8; i++) begin
            run_op(xs[i], ys[i], ds[i], -1, sc, bc, dc, rb);
            e = exp_q.pop_front();
            checks++; if (dc !== 1) $display("FAIL op%0d_done got %0d want 1", i, dc); else passed++;
            checks++; if (hi !== e[63:32]) $display("FAIL op%0d_hi got %h want %h", i, hi, e[63:32]); else passed++;
            checks++; if (lo !== e[31:0]) $display("FAIL op%0d_lo got %h want %h", i, lo, e[31:0]); else passed++;
            end_op();
        end
    endtask

    task automatic test_hold_start();
        int sc, bc, dc, rb;
        logic [63:0] e;
        run_op(32'd123, 32'hFFFFFE38, 1'b0, -1, sc, bc, dc, rb);
        e = exp_q.pop_front();
        checks++; if (busy !== 1'b0) $display("FAIL hold_busy_done got %b want 0", busy); else passed++;
        end_op();
        for (int i = 0; i < 2; i++) begin
            checks++; if (busy !== 1'b0) $display("FAIL hold_busy%0d got %b want 0", i, busy); else passed++;
            checks++; if ({hi, lo} !== e) $display("FAIL hold_hilo%0d got %h want %h", i, {hi, lo}, e); else passed++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_rd_req();
        int sc, bc, dc, rb;
        logic [63:0] e;
        run_op(32'hFFFF1234, 32'd4567, 1'b0, 10, sc, bc, dc, rb);
        e = exp_q.pop_front();
        checks++; if (rb !== 0) $display("FAIL rd_stall_drop got %0d want 0", rb); else passed++;
        checks++; if (stall !== 1'b0) $display("FAIL rd_stall_done got %b want 0", stall); else passed++;
        checks++; if (lo !== e[31:0]) $display("FAIL rd_lo got %h want %h", lo, e[31:0]); else passed++;
        end_op();
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL rd_idle_stall got %b want 0", stall); else passed++;
        checks++; if (hi !== e[63:32]) $display("FAIL rd_idle_hi got %h want %h", hi, e[63:32]); else passed++;
        rd_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int sc, bc, dc, rb, seen;
        logic [63:0] e;
        a = 32'd1000;
        b = 32'd3;
        op_div = 1'b1;
        start = 1'b1;
        exp_q.push_back(model(a, b, 1'b1));
        repeat (15) @(posedge clk);
        #1;
        void'(exp_q.pop_back());
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else passed++;
        checks++; if (hi !== 32'h0) $display("FAIL rstmid_hi got %h want 0", hi); else passed++;
        checks++; if (lo !== 32'h0) $display("FAIL rstmid_lo got %h want 0", lo); else passed++;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL rstmid_done got %0d pulses want 0", seen); else passed++;
        run_op(32'hFFFFFC18, 32'd7, 1'b1, -1, sc, bc, dc, rb);
        e = exp_q.pop_front();
        checks++; if (dc !== 1) $display("FAIL rstmid_fresh_done got %0d want 1", dc); else passed++;
        checks++; if ({hi, lo} !== e) $display("FAIL rstmid_fresh got %h want %h", {hi, lo}, e); else passed++;
        end_op();
    endtask

    task automatic test_back_to_back();
        int sc, bc, dc, rb;
        logic [63:0] e;
        run_op(32'd65537, 32'd65535, 1'b0, -1, sc, bc, dc, rb);
        e = exp_q.pop_front();
        checks++; if ({hi, lo} !== e) $display("FAIL b2b_first got %h want %h", {hi, lo}, e); else passed++;
        @(posedge clk);
        #1;
        run_op(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, -1, sc, bc, dc, rb);
        e = exp_q.pop_front();
        checks++; if (sc !== 34) $display("FAIL b2b_stall got %0d want 34", sc); else passed++;
        checks++; if ({hi, lo} !== e) $display("FAIL b2b_second got %h want %h", {hi, lo}, e); else passed++;
        end_op();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        op_div = 1'b0;
        rd_req = 1'b0;
        a = '0;
        b = '0;
        test_reset();
        test_mult();
        test_ops();
        test_hold_start();
        test_rd_req();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
